// File: rtl/deser_pkg.sv
// Shared constants for the serial deserializer slice.
package deser_pkg;

    localparam int unsigned BIT_ORDER_LSB = 0;
    localparam int unsigned BIT_ORDER_MSB = 1;

endpackage

// File: rtl/deser_shift_core.sv
// Serial shift register and bit counter with frame_sync realignment.
// Flags word_done in the cycle the final bit is accepted.
module deser_shift_core
    import deser_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MSB_FIRST = BIT_ORDER_MSB,
    parameter int unsigned CNT_W     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin_valid,
    input  logic             sin_data,
    input  logic             frame_sync,
    output logic             word_done,
    output logic [WIDTH-1:0] word_next,
    output logic [CNT_W-1:0] bit_count
);

    logic [WIDTH-1:0] shift_q, shift_d, base, shifted;
    logic [CNT_W-1:0] count_q, count_d, eff_count;

    always_comb begin
        // frame_sync drops the partial word before this cycle's bit is considered
        base      = frame_sync ? '0 : shift_q;
        eff_count = frame_sync ? '0 : count_q;
        if (MSB_FIRST == BIT_ORDER_MSB) begin
            shifted = {base[WIDTH-2:0], sin_data};
        end else begin
            shifted = {sin_data, base[WIDTH-1:1]};
        end
        word_done = sin_valid && (eff_count == CNT_W'(WIDTH - 1));
        shift_d   = sin_valid ? shifted : base;
        if (!sin_valid) begin
            count_d = eff_count;
        end else if (word_done) begin
            count_d = '0;
        end else begin
            count_d = eff_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
            count_q <= '0;
        end else begin
            shift_q <= shift_d;
            count_q <= count_d;
        end
    end

    assign word_next = shifted;
    assign bit_count = count_q;

endmodule

// File: rtl/serial_deserializer.sv
// Serial-in/parallel-out deserializer: shift core plus a holding register
// offered on valid/ready, with sticky overrun when a completed word is dropped.
module serial_deserializer
    import deser_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MSB_FIRST = BIT_ORDER_MSB,
    parameter int unsigned CNT_W     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin_valid,
    input  logic             sin_data,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    input  logic             clr_overrun,
    output logic [CNT_W-1:0] bit_count
);

    logic             word_done;
    logic [WIDTH-1:0] word_next;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             load;

    deser_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST),
        .CNT_W     (CNT_W)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .sin_valid  (sin_valid),
        .sin_data   (sin_data),
        .frame_sync (frame_sync),
        .word_done  (word_done),
        .word_next  (word_next),
        .bit_count  (bit_count)
    );

    // A word may load into a slot that is being drained this same cycle
    assign load = word_done && (!valid_q || out_ready);

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (clr_overrun) begin
            overrun_d = 1'b0;
        end
        if (word_done) begin
            if (load) begin
                data_d  = word_next;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_serial_deserializer.sv
// Scoreboard bench for serial_deserializer: MSB-first and LSB-first instances
// share one stimulus stream; accepted words are checked against queued expectations.
module tb_serial_deserializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       sin_valid, sin_data, frame_sync, out_ready, clr_overrun;
    logic [7:0] m_data, l_data;
    logic       m_valid, l_valid, m_ovr, l_ovr;
    logic [2:0] m_cnt, l_cnt;

    logic [7:0] q_msb[$];
    logic [7:0] q_lsb[$];
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    serial_deserializer #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
        .clk         (clk),
        .reset       (reset),
        .sin_valid   (sin_valid),
        .sin_data    (sin_data),
        .frame_sync  (frame_sync),
        .out_data    (m_data),
        .out_valid   (m_valid),
        .out_ready   (out_ready),
        .overrun     (m_ovr),
        .clr_overrun (clr_overrun),
        .bit_count   (m_cnt)
    );

    serial_deserializer #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
        .clk         (clk),
        .reset       (reset),
        .sin_valid   (sin_valid),
        .sin_data    (sin_data),
        .frame_sync  (frame_sync),
        .out_data    (l_data),
        .out_valid   (l_valid),
        .out_ready   (out_ready),
        .overrun     (l_ovr),
        .clr_overrun (clr_overrun),
        .bit_count   (l_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    // Monitor: every accepted word must match the head of the scoreboard
    always @(negedge clk) begin
        if (!reset && m_valid && out_ready) begin
            check("msb_sb_nonempty", 32'(q_msb.size() != 0), 32'd1);
            if (q_msb.size() != 0) check("msb_word", 32'(m_data), 32'(q_msb.pop_front()));
        end
        if (!reset && l_valid && out_ready) begin
            check("lsb_sb_nonempty", 32'(q_lsb.size() != 0), 32'd1);
            if (q_lsb.size() != 0) check("lsb_word", 32'(l_data), 32'(q_lsb.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_bit(input logic b, input logic fs);
        sin_valid  = 1'b1;
        sin_data   = b;
        frame_sync = fs;
        tick();
        sin_valid  = 1'b0;
        sin_data   = 1'b0;
        frame_sync = 1'b0;
    endtask

    // Bits go out w[7] first, so the MSB-first instance reassembles w
    task automatic send_word(input logic [7:0] w, input logic fs, input int gap, input logic push);
        if (push) begin
            q_msb.push_back(w);
            q_lsb.push_back(rev8(w));
        end
        for (int i = 7; i >= 0; i--) begin
            send_bit(w[i], fs && (i == 7));
            if (i > 0) idle(gap);
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w;
        reset = 1'b1; sin_valid = 1'b0; sin_data = 1'b0; frame_sync = 1'b0;
        out_ready = 1'b0; clr_overrun = 1'b0;
        idle(2);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_ovr", 32'(m_ovr), 32'd0);
        check("rst_cnt", 32'(m_cnt), 32'd0);
        reset = 1'b0;
        idle(1);

        // 1: basic word with sync on first bit
        send_word(8'hA5, 1'b1, 0, 1'b1);
        check("t1_valid", 32'(m_valid), 32'd1);
        check("t1_data", 32'(m_data), 32'hA5);
        check("t1_cnt", 32'(m_cnt), 32'd0);
        consume();
        check("t1_valid_clr", 32'(m_valid), 32'd0);
        check("t1_data_hold", 32'(m_data), 32'hA5);

        // 2: bit order
        send_word(8'hC0, 1'b1, 0, 1'b1);
        check("t2_msb", 32'(m_data), 32'hC0);
        check("t2_lsb", 32'(l_data), 32'h03);
        consume();

        // 3: valid every third cycle
        w = 8'h3C;
        q_msb.push_back(w);
        q_lsb.push_back(rev8(w));
        for (int i = 7; i >= 1; i--) begin
            send_bit(w[i], 1'b0);
            idle(2);
        end
        check("t3_cnt7", 32'(m_cnt), 32'd7);
        check("t3_not_valid", 32'(m_valid), 32'd0);
        send_bit(w[0], 1'b0);
        check("t3_valid", 32'(m_valid), 32'd1);
        check("t3_data", 32'(m_data), 32'h3C);
        consume();

        // 4: overrun, clear, and set-beats-clear
        send_word(8'h11, 1'b0, 0, 1'b1);
        send_word(8'h22, 1'b0, 0, 1'b0);
        check("t4_ovr", 32'(m_ovr), 32'd1);
        check("t4_data_kept", 32'(m_data), 32'h11);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        check("t4_ovr_clr", 32'(m_ovr), 32'd0);
        idle(1);
        send_word(8'h22, 1'b0, 0, 1'b0);
        clr_overrun = 1'b1;
        send_word(8'h33, 1'b0, 0, 1'b0);
        clr_overrun = 1'b0;
        check("t4_set_wins", 32'(l_ovr), 32'd1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        consume();
        check("t4_drained", 32'(m_valid), 32'd0);

        // 5: consume and complete in the same cycle, then streaming
        send_word(8'h55, 1'b0, 0, 1'b1);
        w = 8'hAA;
        q_msb.push_back(w);
        q_lsb.push_back(rev8(w));
        for (int i = 7; i >= 1; i--) send_bit(w[i], 1'b0);
        out_ready = 1'b1;
        send_bit(w[0], 1'b0);
        check("t5_valid_kept", 32'(m_valid), 32'd1);
        check("t5_data", 32'(m_data), 32'hAA);
        send_word(8'h0F, 1'b0, 0, 1'b1);
        send_word(8'h96, 1'b0, 0, 1'b1);
        send_word(8'h7E, 1'b0, 0, 1'b1);
        idle(1);
        out_ready = 1'b0;
        check("t5_ovr", 32'(m_ovr), 32'd0);
        check("t5_sb_empty", 32'(q_msb.size()), 32'd0);

        // 6: resync discards stale bits
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_word(8'hF0, 1'b1, 0, 1'b1);
        check("t6_data", 32'(m_data), 32'hF0);
        check("t6_lsb", 32'(l_data), 32'h0F);
        consume();

        // reset mid-word with a held word
        send_word(8'h5A, 1'b0, 0, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b1, i == 0);
        reset = 1'b1;
        #1;
        q_msb.delete();
        q_lsb.delete();
        check("t6_rst_valid", 32'(m_valid), 32'd0);
        check("t6_rst_data", 32'(m_data), 32'd0);
        check("t6_rst_cnt", 32'(m_cnt), 32'd0);
        idle(2);
        reset = 1'b0;
        idle(1);
        send_word(8'h69, 1'b0, 0, 1'b1);
        check("t6_after_rst", 32'(m_data), 32'h69);
        consume();
        idle(2);
        check("end_sb_msb", 32'(q_msb.size()), 32'd0);
        check("end_sb_lsb", 32'(q_lsb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
